// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per completing unit,
// round-robin grant onto a registered broadcast bus, cleared on misbranch flush.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_ID_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*ROB_ID_W-1:0]  src_rob_id,
  input  logic [NUM_SRC*DATA_W-1:0]    src_value,
  input  logic [NUM_SRC*DATA_W-1:0]    src_target_pc,
  input  logic [NUM_SRC-1:0]           src_jump,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value,
  output logic [DATA_W-1:0]            cdb_target_pc,
  output logic                         cdb_jump,
  output logic [1:0]                   cdb_src
);

  logic [NUM_SRC-1:0]  hold_v;
  logic [NUM_SRC-1:0]  hold_jump;
  logic [ROB_ID_W-1:0] hold_id  [NUM_SRC];
  logic [DATA_W-1:0]   hold_val [NUM_SRC];
  logic [DATA_W-1:0]   hold_pc  [NUM_SRC];

  logic [1:0]          last;
  logic [1:0]          idx;
  logic [1:0]          gnt_idx;
  logic                found;
  logic [NUM_SRC-1:0]  grant;
  logic [NUM_SRC-1:0]  accept;

  // Rotating search starting just after the most recently granted source.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = 2'((32'(last) + k) % NUM_SRC);
      if (!found && hold_v[idx]) begin
        found      = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    accept    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rdy && !flush && (!hold_v[i] || grant[i]);
      accept[i]    = src_valid[i] && src_ready[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v        <= '0;
      hold_jump     <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        hold_id[i]  <= '0;
        hold_val[i] <= '0;
        hold_pc[i]  <= '0;
      end
      last          <= 2'(NUM_SRC - 1);
      cdb_valid     <= 1'b0;
      cdb_rob_id    <= '0;
      cdb_value     <= '0;
      cdb_target_pc <= '0;
      cdb_jump      <= 1'b0;
      cdb_src       <= '0;
    end else if (rdy) begin
      if (flush) begin
        hold_v    <= '0;
        cdb_valid <= 1'b0;
      end else begin
        // A refill on the grant edge overrides the clear; rob id 0 is dropped.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (accept[i]) begin
            hold_v[i]    <= (src_rob_id[i*ROB_ID_W +: ROB_ID_W] != '0);
            hold_id[i]   <= src_rob_id[i*ROB_ID_W +: ROB_ID_W];
            hold_val[i]  <= src_value[i*DATA_W +: DATA_W];
            hold_pc[i]   <= src_target_pc[i*DATA_W +: DATA_W];
            hold_jump[i] <= src_jump[i];
          end else if (grant[i]) begin
            hold_v[i]    <= 1'b0;
          end
        end
        if (found) begin
          cdb_valid     <= 1'b1;
          cdb_rob_id    <= hold_id[gnt_idx];
          cdb_value     <= hold_val[gnt_idx];
          cdb_target_pc <= hold_pc[gnt_idx];
          cdb_jump      <= hold_jump[gnt_idx];
          cdb_src       <= gnt_idx;
          last          <= gnt_idx;
        end else begin
          cdb_valid     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the sharing rules.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*IW-1:0] src_rob_id;
  logic [N*DW-1:0] src_value;
  logic [N*DW-1:0] src_target_pc;
  logic [N-1:0]    src_jump;
  logic            cdb_valid;
  logic [IW-1:0]   cdb_rob_id;
  logic [DW-1:0]   cdb_value;
  logic [DW-1:0]   cdb_target_pc;
  logic            cdb_jump;
  logic [1:0]      cdb_src;

  cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ROB_ID_W(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rob_id(src_rob_id),
    .src_value(src_value), .src_target_pc(src_target_pc), .src_jump(src_jump),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_target_pc(cdb_target_pc), .cdb_jump(cdb_jump), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] val;
    logic [DW-1:0] pc;
    logic          jump;
  } ent_t;

  // Model: each source is a queue of at most one result; broadcast is a register.
  ent_t q [N][$];
  int   mlast;
  logic m_v;
  ent_t m_e;
  int   m_src;

  int passed = 0;
  int total  = 0;
  int seen[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      if (q[(mlast + k) % N].size() != 0) return (mlast + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    mlast = N - 1;
    m_v   = 1'b0;
    m_e   = '{default: 0};
    m_src = 0;
  endtask

  task automatic tick();
    int g;
    logic [N-1:0] er;
    #1;
    g = model_grant();
    for (int i = 0; i < N; i++) er[i] = rdy && !flush && (q[i].size() == 0 || g == i);
    chk("src_ready", 64'(src_ready), 64'(er));
    @(posedge clk);
    if (rdy) begin
      if (flush) begin
        for (int i = 0; i < N; i++) q[i].delete();
        m_v = 1'b0;
      end else begin
        if (g >= 0) begin
          m_e   = q[g].pop_front();
          m_v   = 1'b1;
          m_src = g;
          mlast = g;
        end else begin
          m_v = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (src_valid[i] && er[i] && src_rob_id[i*IW +: IW] != '0)
            q[i].push_back('{src_rob_id[i*IW +: IW], src_value[i*DW +: DW],
                             src_target_pc[i*DW +: DW], src_jump[i]});
        end
      end
    end
    #1;
    chk("cdb_valid",     64'(cdb_valid),     64'(m_v));
    chk("cdb_rob_id",    64'(cdb_rob_id),    64'(m_e.id));
    chk("cdb_value",     64'(cdb_value),     64'(m_e.val));
    chk("cdb_target_pc", 64'(cdb_target_pc), 64'(m_e.pc));
    chk("cdb_jump",      64'(cdb_jump),      64'(m_e.jump));
    chk("cdb_src",       64'(cdb_src),       64'(m_src));
    if (cdb_valid) seen.push_back(int'(cdb_rob_id));
  endtask

  task automatic drive(input int i, input logic [IW-1:0] id, input logic [DW-1:0] val);
    src_valid[i]            = 1'b1;
    src_rob_id[i*IW +: IW]  = id;
    src_value[i*DW +: DW]   = val;
    src_target_pc[i*DW +: DW] = val + 32'd4;
    src_jump[i]             = id[0];
  endtask

  // Asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_cdb_valid",  64'(cdb_valid),  64'd0);
    chk("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_cdb_value",  64'(cdb_value),  64'd0);
    chk("rst_cdb_src",    64'(cdb_src),    64'd0);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    int exp3 [4] = '{4, 7, 5, 6};
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    src_valid = '0; src_rob_id = '0; src_value = '0; src_target_pc = '0; src_jump = '0;
    model_reset();
    #12;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_cdb_value", 64'(cdb_value), 64'd0);
    #1 rst = 1'b1;

    // Single source
    drive(0, 5'd3, 32'h2A); tick();
    src_valid = '0; tick();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_id",    64'(cdb_rob_id), 64'd3);
    chk("single_value", 64'(cdb_value), 64'h2A);
    chk("single_src",   64'(cdb_src), 64'd0);
    tick();
    chk("single_gone", 64'(cdb_valid), 64'd0);

    // Three-way contention from last = NUM_SRC-1
    do_reset();
    drive(0, 5'd1, 32'h11); drive(1, 5'd2, 32'h22); drive(2, 5'd3, 32'h33); tick();
    src_valid = '0;
    seen.delete();
    repeat (4) tick();
    chk("contend_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("contend_order", 64'(seen[i]), 64'(i + 1));

    // ALU stream against a held LSU result
    do_reset();
    seen.delete();
    drive(0, 5'd4, 32'h44); drive(1, 5'd7, 32'h77); tick();
    src_valid[1] = 1'b0;
    drive(0, 5'd5, 32'h55); tick();
    drive(0, 5'd6, 32'h66); tick();
    tick();
    src_valid = '0;
    repeat (3) tick();
    chk("stream_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("stream_order", 64'(seen[i]), 64'(exp3[i]));

    // Flush discards held entries
    seen.delete();
    drive(0, 5'd8, 32'h88); drive(1, 5'd9, 32'h99); tick();
    src_valid = '0; flush = 1'b1; tick();
    chk("flush_ready", 64'(src_ready), 64'd0);
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    repeat (3) tick();
    chk("flush_none", 64'(seen.size()), 64'd0);

    // Stall with a pending entry
    drive(0, 5'd10, 32'hA0); tick();
    src_valid = '0; rdy = 1'b0;
    repeat (3) tick();
    chk("stall_valid", 64'(cdb_valid), 64'd0);
    rdy = 1'b1; tick();
    chk("stall_out_valid", 64'(cdb_valid), 64'd1);
    chk("stall_out_id",    64'(cdb_rob_id), 64'd10);

    // Async reset while broadcasting, then priority restarts at source 0
    do_reset();
    drive(0, 5'd11, 32'hB0); drive(2, 5'd12, 32'hC0); tick();
    src_valid = '0; tick();
    chk("post_rst_src", 64'(cdb_src), 64'd0);
    tick();
    chk("post_rst_src2", 64'(cdb_src), 64'd2);
    drive(1, 5'd0, 32'hDEAD); tick();
    src_valid = '0; tick();
    chk("zero_id_dropped", 64'(cdb_valid), 64'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) drive(i, 5'($urandom_range(0, 16)), $urandom);
        else src_valid[i] = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the execution units that complete instructions: ALU, LSU and an optional third unit such as a multiplier.
- The CDB feeds the reorder buffer's completion port and the wakeup logic in the RS/LSB.
- Each source has a one-entry holding register. A round-robin arbiter grants one full holding register per cycle onto a registered CDB.
- All in-flight results are discarded on misbranch flush.

Parameters:
- NUM_SRC, 3, number of requesting units; index 0 = ALU, 1 = LSU, 2 = spare.
- DATA_W, 32, width of result and target-PC fields.
- ROB_ID_W, 5, ROB id width; id 0 = ZERO_ROB (no entry), valid ids are 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global ready; when low, all state is frozen.
- flush  in  1  misbranch flush from the ROB commit stage.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source holding slot can accept this cycle.
- src_rob_id  in  NUM_SRC*ROB_ID_W  packed rob ids; source i occupies bits [i*ROB_ID_W +: ROB_ID_W].
- src_value  in  NUM_SRC*DATA_W  packed results.
- src_target_pc  in  NUM_SRC*DATA_W  packed branch targets; zero for non-branch sources.
- src_jump  in  NUM_SRC  packed precise jump outcome.
- cdb_valid  out  1  registered broadcast valid.
- cdb_rob_id  out  ROB_ID_W  rob id of the broadcast entry.
- cdb_value  out  DATA_W  broadcast result.
- cdb_target_pc  out  DATA_W  broadcast branch target.
- cdb_jump  out  1  broadcast precise jump outcome.
- cdb_src  out  2  index of the granted source (debug and verification).

Behaviour:

Reset (rst low, asynchronous):
- All holding registers empty.
- cdb_valid = 0; cdb_rob_id, cdb_value, cdb_target_pc, cdb_jump, cdb_src = 0.
- Round-robin pointer last = NUM_SRC-1, so source 0 has first priority.
- The reset takes effect immediately, including mid-transfer. Any held results are lost.

rdy low:
- No register changes.
- src_ready is forced to 0.
- CDB outputs hold their previous values.

Per-source holding register hold[i] (valid bit plus fields):
- src_ready[i] = rdy && !flush && (!hold[i].v || grant[i]).
- Accept when src_valid[i] && src_ready[i]: fields are captured at the clock edge.
- src_valid with rob_id == 0 is accepted and dropped; it is never stored.

Arbitration:
- Combinational over the hold[].v bits.
- Search starts at index last+1, wraps modulo NUM_SRC, and takes the first full entry.
- At most one grant per cycle.

Grant cycle:
- The CDB registers load the granted entry and cdb_valid = 1; cdb_src = granted index.
- hold[g] is cleared unless a new accept for g occurs on the same edge; in that case the new data is written, because the refill wins.
- last is set to g.
- With no grant, cdb_valid = 0 and last is unchanged.

Latency:
- A result accepted at edge E0 appears on the CDB in the cycle after edge E1 at the earliest.
- With N sources contending, worst-case wait is NUM_SRC-1 extra cycles.
- Sustained throughput: one broadcast per cycle; each source achieves one per NUM_SRC cycles under full contention.

Flush (sampled high at an edge while rdy):
- All hold[].v cleared; cdb_valid is 0 in the next cycle.
- No accepts occur on that edge.
- last is unchanged.
- Flush has priority over both grant and accept.

Ordering and flow:
- Results from one source are broadcast in acceptance order.
- No ordering is guaranteed between different sources.
- cdb_valid is a single-cycle pulse per entry. No backpressure is applied from consumers; every CDB consumer must sample every cycle.

Test Plan:
- Single source: ALU valid with id=3, value=0x2A at cycle 1 → next cycle cdb_valid=1, id=3, value=0x2A, cdb_src=0; the following cycle cdb_valid=0.
- Three-way contention: all sources valid at once, ids 1, 2, 3, last=2 → CDB order id1 (src 0), id2 (src 1), id3 (src 2) on consecutive cycles; src_ready stays 1 for each source in its grant cycle.
- Back-to-back ALU stream: ALU issues ids 4, 5, 6 every cycle while the LSU holds id 7 → CDB sequence interleaves 4, 7, 5, 6; no ALU result is lost or duplicated.
- Flush: holds filled with ids 8 and 9, flush pulsed → cdb_valid=0 the next cycle; ids 8 and 9 never appear on the CDB; src_ready=0 during the flush cycle.
- rdy low for 3 cycles with id=10 pending → no CDB change during the stall; id=10 is broadcast on the first cycle after rdy returns high.
- Async reset asserted mid-cycle while cdb_valid=1 → outputs go to 0 without waiting for a clock edge; after release, the first grant goes to source 0; a zero rob_id input is never broadcast.
